// File: rtl/uart_echo_tester_if.sv
// uart_echo_tester_if: byte-level handshake between the echo tester and the
// txuartlite / rxuartlite pair.
//   tx_stb   : one-cycle transmit strobe (tester -> tx)
//   tx_data  : byte to transmit, held between strobes (tester -> tx)
//   tx_busy  : transmitter busy (tx -> tester)
//   rx_avail : one-cycle received-byte-valid pulse (rx -> tester)
//   rx_data  : received byte (rx -> tester)
interface uart_echo_tester_if;
  logic       tx_stb;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       rx_avail;
  logic [7:0] rx_data;

  modport master (output tx_stb, output tx_data,
                  input  tx_busy, input rx_avail, input rx_data);
  modport slave  (input  tx_stb, input tx_data,
                  output tx_busy, output rx_avail, output rx_data);
endinterface

// File: rtl/uart_echo_tester.sv
// uart_echo_tester: initiator for the UART echo loop. Sends an incrementing
// byte sequence through the transmit side, waits for each byte to return on
// the receive side, and keeps saturating pass / error / timeout counters.
// Ports:
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_enable         : level-sensitive run request
//   uart (master)    : tx strobe/data/busy, rx avail/data
//   o_pass_count     : matched echoes (saturating)
//   o_err_count      : mismatched or unexpected bytes (saturating)
//   o_timeout_count  : echoes not received in time (saturating)
//   o_led            : last received byte
//   o_busy           : high while not idle
module uart_echo_tester #(
  parameter logic [7:0]  START_BYTE   = 8'h00,
  parameter logic [23:0] TIMEOUT_CLKS = 24'd4340,
  parameter logic [15:0] GAP_CLKS     = 16'd16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  uart_echo_tester_if.master uart,
  output logic [15:0]        o_pass_count,
  output logic [15:0]        o_err_count,
  output logic [15:0]        o_timeout_count,
  output logic [7:0]         o_led,
  output logic               o_busy
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  seq;
  logic [7:0]  txd_r;
  logic        stb_r;
  logic [23:0] tmo_cnt;
  logic [15:0] gap_cnt;

  logic do_stb, inc_pass, inc_err, inc_tmo, seq_inc, led_ld;
  logic tmo_hit, gap_done;

  // Compared one bit wider so a zero parameter behaves as "expire at once"
  // rather than wrapping to the all-ones count.
  assign tmo_hit  = ({1'b0, tmo_cnt} + 25'd1) >= {1'b0, TIMEOUT_CLKS};
  assign gap_done = ({1'b0, gap_cnt} + 17'd1) >= {1'b0, GAP_CLKS};

  assign uart.tx_stb  = stb_r;
  assign uart.tx_data = txd_r;

  always_comb begin
    state_nxt = state;
    do_stb    = 1'b0;
    inc_pass  = 1'b0;
    inc_err   = 1'b0;
    inc_tmo   = 1'b0;
    seq_inc   = 1'b0;
    led_ld    = 1'b0;
    case (state)
      IDLE: begin
        // Stray byte (e.g. a late echo after reset); LEDs left alone.
        if (uart.rx_avail) inc_err = 1'b1;
        if (i_enable) state_nxt = SEND;
      end
      SEND: begin
        if (uart.rx_avail) begin
          inc_err = 1'b1;
          led_ld  = 1'b1;
        end
        if (!uart.tx_busy) begin
          do_stb    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A byte on the expiry cycle takes priority over the timeout.
        if (uart.rx_avail) begin
          if (uart.rx_data == txd_r) inc_pass = 1'b1;
          else                       inc_err  = 1'b1;
          led_ld    = 1'b1;
          seq_inc   = 1'b1;
          state_nxt = GAP;
        end else if (tmo_hit) begin
          inc_tmo   = 1'b1;
          seq_inc   = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (uart.rx_avail) begin
          inc_err = 1'b1;
          led_ld  = 1'b1;
        end
        if (gap_done) state_nxt = i_enable ? SEND : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= IDLE;
      stb_r           <= 1'b0;
      txd_r           <= START_BYTE;
      seq             <= START_BYTE;
      tmo_cnt         <= '0;
      gap_cnt         <= '0;
      o_pass_count    <= '0;
      o_err_count     <= '0;
      o_timeout_count <= '0;
      o_led           <= '0;
      o_busy          <= 1'b0;
    end else begin
      state  <= state_nxt;
      stb_r  <= do_stb;
      o_busy <= (state_nxt != IDLE);
      if (do_stb) txd_r <= seq;
      if (seq_inc) seq <= seq + 8'd1;

      if (do_stb)             tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + 24'd1;

      // Restarts from zero on every entry into GAP.
      if (state != GAP) gap_cnt <= '0;
      else              gap_cnt <= gap_cnt + 16'd1;

      if (led_ld) o_led <= uart.rx_data;

      if (inc_pass && o_pass_count != 16'hFFFF)
        o_pass_count <= o_pass_count + 16'd1;
      if (inc_err && o_err_count != 16'hFFFF)
        o_err_count <= o_err_count + 16'd1;
      if (inc_tmo && o_timeout_count != 16'hFFFF)
        o_timeout_count <= o_timeout_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_echo_tester.sv
module tb_uart_echo_tester;
  localparam logic [7:0] START = 8'h00;
  localparam int TMO  = 100;
  localparam int GAP  = 16;
  localparam int GAPD = ((GAP > 0) ? GAP : 1) + 1;  // done -> next strobe

  logic        i_clk = 1'b0;
  logic        i_reset, i_enable;
  logic [15:0] pass_c, err_c, tmo_c;
  logic [7:0]  led;
  logic        busy;

  uart_echo_tester_if u_if();

  uart_echo_tester #(
    .START_BYTE(START), .TIMEOUT_CLKS(24'(TMO)), .GAP_CLKS(16'(GAP))
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .uart(u_if.master),
    .o_pass_count(pass_c), .o_err_count(err_c), .o_timeout_count(tmo_c),
    .o_led(led), .o_busy(busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, errs = 0, cyc = 0, done_cyc = 0;
  bit found, wrap_seen;
  logic [7:0] prev_sent;

  // reference model state
  logic [7:0] m_seq, m_led;
  int m_pass, m_err, m_tmo;

  function automatic int sat(input int v);
    return (v < 65535) ? v + 1 : 65535;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    cyc++;
  endtask

  task automatic chk_counts();
    chk("pass_count", pass_c, m_pass);
    chk("err_count",  err_c,  m_err);
    chk("tmo_count",  tmo_c,  m_tmo);
    chk("led",        led,    m_led);
  endtask

  task automatic wait_stb(input int ref_c, input int exp_d);
    found = 0;
    u_if.rx_avail = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      tick();
      if (u_if.tx_stb) found = 1;
    end
    if (!found) chk("stb_seen", 0, 1);
    else if (exp_d >= 0) chk("stb_latency", cyc - ref_c, exp_d);
  endtask

  // One transaction: echo offered k cycles after the strobe cycle (k >= TMO
  // means no echo). Model: echo wins through cycle TMO-1, else a timeout.
  task automatic run_txn(input int ref_c, input int exp_d, input int k,
                         input logic [7:0] rxd, input bit drop_en);
    logic [7:0] sent;
    int r;
    wait_stb(ref_c, exp_d);
    if (!found) return;
    sent = u_if.tx_data;
    chk("tx_data", sent, m_seq);
    if (prev_sent == 8'hFF && sent == 8'h00) wrap_seen = 1;
    prev_sent = sent;
    if (drop_en) i_enable = 1'b0;
    r = (k < TMO) ? k : TMO - 1;
    for (int j = 0; j <= r + 1; j++) begin
      if (j > 0) tick();
      if (j == 1) chk("stb_one_cycle", u_if.tx_stb, 0);
      if (j == r) chk("tmo_not_early", tmo_c, m_tmo);
      if (j == k) begin
        u_if.rx_avail = 1'b1;
        u_if.rx_data  = rxd;
      end else begin
        u_if.rx_avail = 1'b0;
      end
    end
    if (k < TMO) begin
      if (rxd == m_seq) m_pass = sat(m_pass);
      else              m_err  = sat(m_err);
      m_led = rxd;
    end else begin
      m_tmo = sat(m_tmo);
    end
    m_seq = m_seq + 8'd1;
    chk_counts();
    chk("tx_data_hold", u_if.tx_data, sent);
    done_cyc = cyc;
  endtask

  task automatic stray_in_gap();
    logic [7:0] b;
    b = 8'($urandom);
    tick();
    tick();
    u_if.rx_avail = 1'b1;
    u_if.rx_data  = b;
    tick();
    u_if.rx_avail = 1'b0;
    m_err = sat(m_err);
    m_led = b;
    chk("gap_stray_err", err_c, m_err);
    chk("gap_stray_led", led, m_led);
  endtask

  task automatic model_reset();
    m_seq = START; m_led = 8'h00;
    m_pass = 0; m_err = 0; m_tmo = 0;
    prev_sent = 8'h00;
  endtask

  task automatic chk_reset_state();
    chk("rst_stb",  u_if.tx_stb, 0);
    chk("rst_data", u_if.tx_data, START);
    chk("rst_led",  led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass_c, 0);
    chk("rst_err",  err_c, 0);
    chk("rst_tmo",  tmo_c, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, mode, k;
    logic [7:0] b;
    i_reset = 1'b1; i_enable = 1'b0;
    u_if.tx_busy = 1'b0; u_if.rx_avail = 1'b0; u_if.rx_data = 8'h00;
    wrap_seen = 0;
    model_reset();
    repeat (3) tick();
    i_reset = 1'b0;
    tick();
    chk_reset_state();

    // Loopback, echo 5 cycles after each strobe; first strobe 2 cycles after enable.
    i_enable = 1'b1;
    run_txn(cyc, 2, 5, m_seq, 0);
    repeat (2) run_txn(done_cyc, GAPD, 5, m_seq, 0);
    // Corrupted echoes.
    repeat (2) run_txn(done_cyc, GAPD, 5, m_seq ^ 8'h01, 0);
    // No echo: timeout exactly TMO cycles after the strobe.
    repeat (2) run_txn(done_cyc, GAPD, 1000, 8'h00, 0);
    // Echo on the expiry cycle.
    run_txn(done_cyc, GAPD, TMO - 1, m_seq, 0);

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0: run_txn(done_cyc, GAPD, $urandom_range(0, 30), m_seq, 0);
        1: run_txn(done_cyc, GAPD, $urandom_range(0, 30), m_seq ^ 8'($urandom_range(1, 255)), 0);
        2: run_txn(done_cyc, GAPD, 1000, 8'h00, 0);
        3: begin
          b = ($urandom_range(0, 1) == 1) ? m_seq : 8'($urandom);
          run_txn(done_cyc, GAPD, TMO - 1, b, 0);
        end
        default: begin
          run_txn(done_cyc, GAPD, $urandom_range(0, 10), m_seq, 0);
          stray_in_gap();
        end
      endcase
    end

    // Drop enable mid-transaction: it completes, then the block idles.
    run_txn(done_cyc, GAPD, 10, m_seq, 1);
    cnt = 0;
    for (int j = 1; j <= 24; j++) begin
      tick();
      if (u_if.tx_stb) cnt++;
      if (j == GAP - 1) chk("busy_in_gap", busy, 1);
      if (j == GAP) chk("busy_idle", busy, 0);
    end
    chk("no_stb_idle", cnt, 0);

    // Stray byte in IDLE: error only.
    b = 8'($urandom);
    u_if.rx_avail = 1'b1; u_if.rx_data = b;
    tick();
    u_if.rx_avail = 1'b0;
    m_err = sat(m_err);
    chk("idle_stray_err", err_c, m_err);
    chk("idle_stray_led", led, m_led);

    // Transmitter busy for 50 cycles in SEND, resume from current sequence.
    u_if.tx_busy = 1'b1;
    i_enable = 1'b1;
    cnt = 0;
    repeat (50) begin
      tick();
      if (u_if.tx_stb) cnt++;
    end
    chk("busy_no_stb", cnt, 0);
    chk("busy_o_busy", busy, 1);
    u_if.tx_busy = 1'b0;
    run_txn(cyc, 1, 3, m_seq, 0);

    // Long run of passes through the FF -> 00 wrap.
    for (int i = 0; i < 260; i++)
      run_txn(done_cyc, GAPD, $urandom_range(0, 3), m_seq, 0);
    chk("seq_wrap_seen", wrap_seen, 1);

    // Reset while waiting for an echo.
    wait_stb(done_cyc, GAPD);
    repeat (3) tick();
    i_reset = 1'b1; i_enable = 1'b0;
    tick();
    i_reset = 1'b0;
    chk_reset_state();
    model_reset();
    i_enable = 1'b1;
    run_txn(cyc, 2, 4, m_seq, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
